// File: rtl/iob_merge_arb_pkg.sv
// Shared constants and types for the IOb merge arbiter.
// Width helpers keep 1-bit minimums so N=1 / depth-1 builds still elaborate.
package iob_merge_arb_pkg;

  function automatic int unsigned min1_clog2(input int unsigned v);
    return ($clog2(v) == 0) ? 1 : $clog2(v);
  endfunction

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_st_e;

endpackage

// File: rtl/iob_merge_route_fifo.sv
// Route FIFO holding the owning master index of each read in flight.
// dout shows the head entry combinationally; push when full and pop when empty are ignored.
module iob_merge_route_fifo
  import iob_merge_arb_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         cke_i,
  input  logic         arst_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PtrW = min1_clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else if (cke_i) begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/iob_merge_arb.sv
// N-master to 1-slave IOb merge with round-robin arbitration and in-order read routing.
// Optional sticky stray-response flag err_o when IOB_MERGE_ARB_ERR_EN is defined.
module iob_merge_arb
  import iob_merge_arb_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned N               = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  input  logic [N-1:0]            m_avalid_i,
  input  logic [N*ADDR_W-1:0]     m_addr_i,
  input  logic [N*DATA_W-1:0]     m_wdata_i,
  input  logic [N*DATA_W/8-1:0]   m_wstrb_i,
  output logic [N-1:0]            m_ready_o,
  output logic [N*DATA_W-1:0]     m_rdata_o,
  output logic [N-1:0]            m_rvalid_o,
  output logic                    s_avalid_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic [DATA_W-1:0]       s_wdata_o,
  output logic [DATA_W/8-1:0]     s_wstrb_o,
  input  logic                    s_ready_i,
  input  logic [DATA_W-1:0]       s_rdata_i,
`ifdef IOB_MERGE_ARB_ERR_EN
  input  logic                    s_rvalid_i,
  output logic                    err_o
`else
  input  logic                    s_rvalid_i
`endif
);

  localparam int unsigned NBITS  = min1_clog2(N);
  localparam int unsigned STRB_W = DATA_W / 8;

  lock_st_e         lock_st_q, lock_st_d;
  logic [NBITS-1:0] lock_idx_q, lock_idx_d;
  logic [NBITS-1:0] last_grant_q, last_grant_d;

  logic [NBITS-1:0]  grant;
  logic              req;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              is_read, block, avalid, acc;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [NBITS-1:0]  fifo_head;

  // Round-robin search starting just after the last accepted master; lock pins the grant.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_grant_q) + i) % N;
      if (!found && m_avalid_i[idx]) begin
        found = 1'b1;
        grant = NBITS'(idx);
      end
    end
    if (lock_st_q == StLocked) begin
      grant = lock_idx_q;
    end
  end

  always_comb begin
    req     = m_avalid_i[grant];
    g_addr  = '0;
    g_wdata = '0;
    g_wstrb = '0;
    if (req) begin
      g_addr  = m_addr_i[int'(grant)*ADDR_W +: ADDR_W];
      g_wdata = m_wdata_i[int'(grant)*DATA_W +: DATA_W];
      g_wstrb = m_wstrb_i[int'(grant)*STRB_W +: STRB_W];
    end
    is_read = (g_wstrb == '0);
    block   = is_read & fifo_full;
    avalid  = req & ~block & ~arst_i;
    acc     = avalid & s_ready_i;
  end

  assign s_avalid_o = avalid;
  assign s_addr_o   = arst_i ? '0 : g_addr;
  assign s_wdata_o  = arst_i ? '0 : g_wdata;
  assign s_wstrb_o  = arst_i ? '0 : g_wstrb;
  assign m_ready_o  = N'(acc) << grant;

  always_comb begin
    lock_st_d    = lock_st_q;
    lock_idx_d   = lock_idx_q;
    last_grant_d = last_grant_q;
    if (acc) begin
      last_grant_d = grant;
    end
    unique case (lock_st_q)
      StUnlocked: begin
        if (avalid && !s_ready_i) begin
          lock_st_d  = StLocked;
          lock_idx_d = grant;
        end
      end
      StLocked: begin
        if (acc) begin
          lock_st_d = StUnlocked;
        end
      end
      default: lock_st_d = StUnlocked;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lock_st_q    <= StUnlocked;
      lock_idx_q   <= '0;
      last_grant_q <= NBITS'(N - 1);
    end else if (cke_i) begin
      lock_st_q    <= lock_st_d;
      lock_idx_q   <= lock_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign fifo_pop = s_rvalid_i & ~fifo_empty;

  iob_merge_route_fifo #(
    .W     (NBITS),
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .arst_i (arst_i),
    .push   (acc & is_read),
    .din    (grant),
    .pop    (fifo_pop),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (fifo_pop && !arst_i && (fifo_head == NBITS'(k))) begin
        m_rvalid_o[k]                = 1'b1;
        m_rdata_o[k*DATA_W +: DATA_W] = s_rdata_i;
      end
    end
  end

`ifdef IOB_MERGE_ARB_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (s_rvalid_i & fifo_empty);
  assign err_o = err_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_q <= 1'b0;
    end else if (cke_i) begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_iob_merge_arb.sv
// Directed bench for iob_merge_arb: N=3, depth 4, table of per-cycle vectors plus a reset sequence.
module tb_iob_merge_arb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NM = 3;
  localparam int unsigned MO = 4;

  logic              clk, cke, arst;
  logic [NM-1:0]     m_avalid;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*DW/8-1:0] m_wstrb;
  logic [NM-1:0]     m_ready;
  logic [NM*DW-1:0]  m_rdata;
  logic [NM-1:0]     m_rvalid;
  logic              s_avalid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wstrb;
  logic              s_ready, s_rvalid;
  logic [DW-1:0]     s_rdata;
`ifdef IOB_MERGE_ARB_ERR_EN
  logic              err;
`endif

  int total = 0;
  int bad   = 0;

  iob_merge_arb #(
    .DATA_W          (DW),
    .ADDR_W          (AW),
    .N               (NM),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .arst_i     (arst),
    .m_avalid_i (m_avalid),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_wstrb_i  (m_wstrb),
    .m_ready_o  (m_ready),
    .m_rdata_o  (m_rdata),
    .m_rvalid_o (m_rvalid),
    .s_avalid_o (s_avalid),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_wstrb_o  (s_wstrb),
    .s_ready_i  (s_ready),
    .s_rdata_i  (s_rdata),
`ifdef IOB_MERGE_ARB_ERR_EN
    .s_rvalid_i (s_rvalid),
    .err_o      (err)
`else
    .s_rvalid_i (s_rvalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cke;
    logic [2:0]  av;
    logic [2:0]  wr;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_sav;
    logic [31:0] e_addr;
    logic [2:0]  e_mrdy;
    logic [2:0]  e_rv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic [2:0] av, input logic [2:0] wr,
                              input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic esav, input logic [31:0] eaddr,
                              input logic [2:0] emr, input logic [2:0] erv);
    vec_t v;
    v.cke = c; v.av = av; v.wr = wr; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_sav = esav; v.e_addr = eaddr; v.e_mrdy = emr; v.e_rv = erv;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [2:0] av, input logic [2:0] wr,
                       input logic rdy, input logic rv, input logic [31:0] rd);
    cke      = c;
    m_avalid = av;
    for (int k = 0; k < int'(NM); k++) begin
      m_wstrb[k*4 +: 4] = wr[k] ? 4'hF : 4'h0;
    end
    s_ready  = rdy;
    s_rvalid = rv;
    s_rdata  = rd;
  endtask

  function automatic logic [NM*DW-1:0] exp_rdata(input logic [2:0] rvm, input logic [31:0] rd);
    logic [NM*DW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NM); k++) begin
      if (rvm[k]) r[k*DW +: DW] = rd;
    end
    return r;
  endfunction

  initial begin
    for (int k = 0; k < int'(NM); k++) begin
      m_addr[k*AW +: AW]  = 32'h100 * (k + 1);
      m_wdata[k*DW +: DW] = 32'hD0 + k;
    end

    // Fairness with overlapping push/pop, then drain and a stray response
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 0, 32'h0,  1, 32'h200, 3'b010, 3'b000));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 0, 32'h0,  1, 32'h300, 3'b100, 3'b000));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 1, 32'hA,  1, 32'h100, 3'b001, 3'b001));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 1, 32'hB,  1, 32'h200, 3'b010, 3'b010));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 1, 32'hC,  1, 32'h300, 3'b100, 3'b100));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h1,  0, 32'h0,   3'b000, 3'b001));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h2,  0, 32'h0,   3'b000, 3'b010));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h3,  0, 32'h0,   3'b000, 3'b100));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h55, 0, 32'h0,   3'b000, 3'b000));
    // Lock on master 1 while the slave stalls, including a dropped request
    tbl.push_back(mk(1, 3'b001, 3'b001, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b011, 3'b011, 0, 0, 32'h0,  1, 32'h200, 3'b000, 3'b000));
    tbl.push_back(mk(1, 3'b101, 3'b011, 0, 0, 32'h0,  0, 32'h0,   3'b000, 3'b000));
    tbl.push_back(mk(1, 3'b011, 3'b011, 0, 0, 32'h0,  1, 32'h200, 3'b000, 3'b000));
    tbl.push_back(mk(1, 3'b011, 3'b011, 1, 0, 32'h0,  1, 32'h200, 3'b010, 3'b000));
    tbl.push_back(mk(1, 3'b001, 3'b001, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    // Fill FIFO, blocked read, write passes, no same-cycle bypass
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 0, 32'h0,  1, 32'h200, 3'b010, 3'b000));
    tbl.push_back(mk(1, 3'b100, 3'b000, 1, 0, 32'h0,  1, 32'h300, 3'b100, 3'b000));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b010, 3'b000, 1, 0, 32'h0,  1, 32'h200, 3'b010, 3'b000));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 0, 32'h0,  0, 32'h100, 3'b000, 3'b000));
    tbl.push_back(mk(1, 3'b101, 3'b100, 1, 0, 32'h0,  1, 32'h300, 3'b100, 3'b000));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 1, 32'h77, 0, 32'h100, 3'b000, 3'b010));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'hA1, 0, 32'h0,   3'b000, 3'b100));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'hA2, 0, 32'h0,   3'b000, 3'b001));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'hA3, 0, 32'h0,   3'b000, 3'b010));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'hA4, 0, 32'h0,   3'b000, 3'b001));
    // Interleaved owners 2,0,2
    tbl.push_back(mk(1, 3'b100, 3'b000, 1, 0, 32'h0,  1, 32'h300, 3'b100, 3'b000));
    tbl.push_back(mk(1, 3'b001, 3'b000, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b100, 3'b000, 1, 0, 32'h0,  1, 32'h300, 3'b100, 3'b000));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h11, 0, 32'h0,   3'b000, 3'b100));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h22, 0, 32'h0,   3'b000, 3'b001));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h33, 0, 32'h0,   3'b000, 3'b100));
    // Clock enable low: combinational accept visible but nothing recorded
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b111, 3'b000, 1, 0, 32'h0,  1, 32'h100, 3'b001, 3'b000));
    tbl.push_back(mk(1, 3'b000, 3'b000, 1, 1, 32'h44, 0, 32'h0,   3'b000, 3'b001));

    arst = 1'b1;
    drive(1, 3'b111, 3'b000, 1, 1, 32'hEE);
    #3;
    check("reset s_avalid", 128'(s_avalid), 128'(1'b0));
    check("reset m_ready", 128'(m_ready), 128'(3'b000));
    check("reset m_rvalid", 128'(m_rvalid), 128'(3'b000));
    check("reset m_rdata", 128'(m_rdata), 128'(0));
    check("reset s_addr", 128'(s_addr), 128'(0));
`ifdef IOB_MERGE_ARB_ERR_EN
    check("reset err", 128'(err), 128'(1'b0));
`endif
    @(negedge clk);
    arst = 1'b0;
    drive(1, 3'b000, 3'b000, 0, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].cke, tbl[i].av, tbl[i].wr, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      #2;
      check($sformatf("vec%0d s_avalid", i), 128'(s_avalid), 128'(tbl[i].e_sav));
      check($sformatf("vec%0d s_addr", i), 128'(s_addr), 128'(tbl[i].e_addr));
      check($sformatf("vec%0d m_ready", i), 128'(m_ready), 128'(tbl[i].e_mrdy));
      check($sformatf("vec%0d m_rvalid", i), 128'(m_rvalid), 128'(tbl[i].e_rv));
      check($sformatf("vec%0d m_rdata", i), 128'(m_rdata),
            128'(exp_rdata(tbl[i].e_rv, tbl[i].rd)));
    end

    // Reset with two reads outstanding (owners 1 then 0), then a stray response
    @(negedge clk);
    drive(1, 3'b011, 3'b000, 1, 0, 32'h0);
    #2 check("rst_seq rd1 m_ready", 128'(m_ready), 128'(3'b010));
    @(negedge clk);
    drive(1, 3'b001, 3'b000, 1, 0, 32'h0);
    #2 check("rst_seq rd2 m_ready", 128'(m_ready), 128'(3'b001));
    @(negedge clk);
    drive(1, 3'b111, 3'b000, 1, 1, 32'hEE);
    #1 arst = 1'b1;
    #1;
    check("rst_seq s_avalid", 128'(s_avalid), 128'(1'b0));
    check("rst_seq m_ready", 128'(m_ready), 128'(3'b000));
    check("rst_seq m_rvalid", 128'(m_rvalid), 128'(3'b000));
    check("rst_seq m_rdata", 128'(m_rdata), 128'(0));
    check("rst_seq s_addr", 128'(s_addr), 128'(0));
    check("rst_seq s_wstrb", 128'(s_wstrb), 128'(0));
    check("rst_seq s_wdata", 128'(s_wdata), 128'(0));
    @(negedge clk);
    arst = 1'b0;
    drive(1, 3'b000, 3'b000, 1, 1, 32'h99);
    #2;
    check("stray m_rvalid", 128'(m_rvalid), 128'(3'b000));
    check("stray m_rdata", 128'(m_rdata), 128'(0));
`ifdef IOB_MERGE_ARB_ERR_EN
    check("stray err same cycle", 128'(err), 128'(1'b0));
`endif
    @(negedge clk);
    drive(1, 3'b000, 3'b000, 1, 0, 32'h0);
    #2;
`ifdef IOB_MERGE_ARB_ERR_EN
    check("stray err next cycle", 128'(err), 128'(1'b1));
`endif
    @(negedge clk);
    drive(1, 3'b111, 3'b000, 1, 0, 32'h0);
    #2;
    check("post-reset s_addr", 128'(s_addr), 128'(32'h100));
    check("post-reset m_ready", 128'(m_ready), 128'(3'b001));
    @(negedge clk);
    drive(1, 3'b000, 3'b000, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
